// File: rtl/serial_sub_flags_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and
// the default operand width.
package serial_sub_flags_pkg;

  localparam int SUB_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_sub_flags_full_adder_bit.sv
// One-bit full adder used as the serial datapath core of serial_sub_flags.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  // Plain combinational sum and carry-out.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

// File: rtl/serial_sub_flags.sv
// Bit-serial subtractor diff = R2 - R3 (mod 2^N), one bit per cycle LSB first,
// producing registered slt / zero / ovf flags behind a valid/ready handshake.
// Optional feature: define SERIAL_SUB_SLTU_EN to add the unsigned less-than
// output sltu.
module serial_sub_flags
  import serial_sub_flags_pkg::*;
#(
  parameter int N = SUB_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] R2,
  input  logic [N-1:0] R3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         slt,
  output logic         zero,
`ifdef SERIAL_SUB_SLTU_EN
  output logic         sltu,
`endif
  output logic         ovf
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sub_state_e state_q, state_d;

  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cin_msb_q, cin_msb_d;
  // Set once all N bits are in; the following SHIFT cycle registers the flags.
  logic          fin_q, fin_d;
  logic          slt_q, slt_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
`ifdef SERIAL_SUB_SLTU_EN
  logic          sltu_q, sltu_d;
`endif

  logic          fa_sum;
  logic          fa_cout;
  logic          ovf_calc;

  // Subtraction as a + ~b + 1: the +1 comes from carry starting at 1.
  full_adder_bit u_fa (
    .a_i (a_q[0]),
    .b_i (~b_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (fin_q)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign ovf_calc = cin_msb_q ^ carry_q;

  // Datapath next-state: capture, serial shift, then flag evaluation.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    fin_d     = fin_q;
    slt_d     = slt_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
`ifdef SERIAL_SUB_SLTU_EN
    sltu_d    = sltu_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = R2;
          b_d     = R3;
          carry_d = 1'b1;
          cnt_d   = '0;
          fin_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (!fin_q) begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          diff_d  = {fa_sum, diff_q[N-1:1]};
          carry_d = fa_cout;
          if (cnt_q == CNT_LAST) begin
            // Keep the carry into the sign bit for the overflow flag.
            cin_msb_d = carry_q;
            fin_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          ovf_d  = ovf_calc;
          slt_d  = diff_q[N-1] ^ ovf_calc;
          zero_d = (diff_q == '0);
`ifdef SERIAL_SUB_SLTU_EN
          sltu_d = ~carry_q;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      fin_q     <= 1'b0;
      slt_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef SERIAL_SUB_SLTU_EN
      sltu_q    <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      fin_q     <= fin_d;
      slt_q     <= slt_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
`ifdef SERIAL_SUB_SLTU_EN
      sltu_q    <= sltu_d;
`endif
    end
  end

  assign diff = diff_q;
  assign slt  = slt_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
`ifdef SERIAL_SUB_SLTU_EN
  assign sltu = sltu_q;
`endif

endmodule
